// File: rtl/seq_divider_if.sv
// Handshake/operand bundle between the control unit (master) and seq_divider (slave).
// signed_op exists only when SIGNED_DIV_EN is defined.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
`ifdef SIGNED_DIV_EN
  logic             signed_op;
`endif
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
`ifdef SIGNED_DIV_EN
    output signed_op,
`endif
    output dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start,
`ifdef SIGNED_DIV_EN
    input  signed_op,
`endif
    input  dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle through a CLA-style subtract.
// Optional signed support via SIGNED_DIV_EN (magnitude divide plus sign fix-up on DONE entry).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q, q_q, divisor_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, remd_q;

  logic [WIDTH-1:0] dvd_mag_d, dvs_mag_d;
  logic             neg_q_d, neg_r_d;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_d, q_d, quot_d, remd_d;

`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_r_q;

  always_comb begin
    dvd_mag_d = bus.dividend;
    dvs_mag_d = bus.divisor;
    neg_q_d   = 1'b0;
    neg_r_d   = 1'b0;
    if (bus.signed_op) begin
      // MIN maps onto itself, which is its correct unsigned magnitude.
      if (bus.dividend[WIDTH-1]) dvd_mag_d = -bus.dividend;
      if (bus.divisor[WIDTH-1])  dvs_mag_d = -bus.divisor;
      neg_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r_d = bus.dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    dvd_mag_d = bus.dividend;
    dvs_mag_d = bus.divisor;
    neg_q_d   = 1'b0;
    neg_r_d   = 1'b0;
  end
`endif

  // Partial remainder is WIDTH+1 bits after the shift, so large divisors never wrap.
  always_comb begin
    rem_sh = {rem_q, q_q[WIDTH-1]};
    diff   = rem_sh + ~{1'b0, divisor_q} + {{WIDTH{1'b0}}, 1'b1};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], 1'b0};
    end
`ifdef SIGNED_DIV_EN
    quot_d = neg_q_q ? -q_d   : q_d;
    remd_d = neg_r_q ? -rem_d : rem_d;
`else
    quot_d = q_d;
    remd_d = rem_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      remd_q    <= '0;
`ifdef SIGNED_DIV_EN
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              remd_q  <= bus.dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q   <= RUN;
              rem_q     <= '0;
              q_q       <= dvd_mag_d;
              divisor_q <= dvs_mag_d;
              cnt_q     <= CW'(WIDTH-1);
`ifdef SIGNED_DIV_EN
              neg_q_q   <= neg_q_d;
              neg_r_q   <= neg_r_d;
`endif
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dbz_q;
endmodule
